// File: rtl/logic_axi4_stream_if.sv
// logic_axi4_stream_if: AXI4-Stream signal bundle with receive/transmit modports
interface logic_axi4_stream_if #(
   parameter int TDATA_BYTES = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TID_WIDTH   = 1
);
   localparam int DW = TDATA_BYTES > 0 ? TDATA_BYTES * 8 : 1;
   localparam int KW = TDATA_BYTES > 0 ? TDATA_BYTES : 1;
   localparam int EW = TDEST_WIDTH > 0 ? TDEST_WIDTH : 1;
   localparam int UW = TUSER_WIDTH > 0 ? TUSER_WIDTH : 1;
   localparam int IW = TID_WIDTH > 0 ? TID_WIDTH : 1;
   logic          tvalid;
   logic          tready;
   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic [KW-1:0] tstrb;
   logic          tlast;
   logic [EW-1:0] tdest;
   logic [UW-1:0] tuser;
   logic [IW-1:0] tid;
   modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tdest, tuser, tid, output tready);
   modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tdest, tuser, tid, input tready);
endinterface

// File: rtl/logic_axi4_stream_packet_arbiter.sv
// logic_axi4_stream_packet_arbiter: packet-level round-robin merge of several AXI4-Stream sources
module logic_axi4_stream_packet_arbiter #(
   parameter int INPUTS      = 2,
   parameter int TDATA_BYTES = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TID_WIDTH   = 1,
   parameter int USE_TLAST   = 1,
   parameter int USE_TKEEP   = 1,
   parameter int USE_TSTRB   = 1,
   parameter int SET_TID     = 0
) (
   input logic             aclk,
   input logic             areset_n,
   logic_axi4_stream_if.rx rx [INPUTS],
   logic_axi4_stream_if.tx tx
);
   localparam int PW = $clog2(INPUTS);
   localparam int DW = TDATA_BYTES > 0 ? TDATA_BYTES * 8 : 1;
   localparam int KW = TDATA_BYTES > 0 ? TDATA_BYTES : 1;
   localparam int EW = TDEST_WIDTH > 0 ? TDEST_WIDTH : 1;
   localparam int UW = TUSER_WIDTH > 0 ? TUSER_WIDTH : 1;
   localparam int IW = TID_WIDTH > 0 ? TID_WIDTH : 1;

   if (INPUTS < 2) begin : g_chk_inputs
      $error("INPUTS must be at least 2");
   end
   if (SET_TID != 0 && TID_WIDTH < PW) begin : g_chk_tid
      $error("SET_TID needs TID_WIDTH >= clog2(INPUTS)");
   end

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   grant;
   logic [PW-1:0]   pick;
   logic [PW-1:0]   cand;
   logic [PW-1:0]   sel;
   logic [PW-1:0]   nxt;
   logic            found;
   logic            have_sel;
   logic            load;
   logic            accept;
   logic            last_eff;
   logic            out_valid;
   logic [INPUTS-1:0] in_valid;
   logic [INPUTS-1:0] in_last;
   logic [DW-1:0]   in_data [INPUTS];
   logic [KW-1:0]   in_keep [INPUTS];
   logic [KW-1:0]   in_strb [INPUTS];
   logic [EW-1:0]   in_dest [INPUTS];
   logic [UW-1:0]   in_user [INPUTS];
   logic [IW-1:0]   in_id   [INPUTS];
   logic [DW-1:0]   data_q;
   logic [KW-1:0]   keep_q;
   logic [KW-1:0]   strb_q;
   logic            last_q;
   logic [EW-1:0]   dest_q;
   logic [UW-1:0]   user_q;
   logic [IW-1:0]   id_q;

   for (genvar i = 0; i < INPUTS; i++) begin : g_in
      assign in_valid[i] = rx[i].tvalid;
      assign in_last[i]  = rx[i].tlast;
      assign in_data[i]  = rx[i].tdata;
      assign in_keep[i]  = rx[i].tkeep;
      assign in_strb[i]  = rx[i].tstrb;
      assign in_dest[i]  = rx[i].tdest;
      assign in_user[i]  = rx[i].tuser;
      assign in_id[i]    = rx[i].tid;
      assign rx[i].tready = load && have_sel && (sel == PW'(i));
   end

   // first valid input at or after ptr, wrapping modulo INPUTS
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < INPUTS; k++) begin
         cand = PW'((int'(ptr) + k) % INPUTS);
         if (!found && in_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign sel      = state == LOCKED ? grant : pick;
   assign have_sel = state == LOCKED || found;
   assign load     = tx.tready || !out_valid;
   assign accept   = load && have_sel && in_valid[sel];
   assign last_eff = USE_TLAST != 0 ? in_last[sel] : 1'b1;
   assign nxt      = sel == PW'(INPUTS - 1) ? '0 : sel + 1'b1;

   // grant state, priority pointer and output valid
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state     <= IDLE;
         grant     <= '0;
         ptr       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (load) out_valid <= accept;
         if (accept && last_eff) begin
            state <= IDLE;
            ptr   <= nxt;
         end else if (accept) begin
            state <= LOCKED;
            grant <= sel;
         end
      end
   end

   // payload capture of the accepted beat; held while the output stalls
   always_ff @(posedge aclk) begin
      if (accept) begin
         data_q <= in_data[sel];
         keep_q <= in_keep[sel];
         strb_q <= in_strb[sel];
         last_q <= in_last[sel];
         dest_q <= in_dest[sel];
         user_q <= in_user[sel];
         id_q   <= SET_TID != 0 ? IW'(sel) : in_id[sel];
      end
   end

   assign tx.tvalid = out_valid;
   assign tx.tdata  = TDATA_BYTES > 0 ? data_q : '0;
   assign tx.tkeep  = (TDATA_BYTES > 0 && USE_TKEEP != 0) ? keep_q : '1;
   assign tx.tstrb  = (TDATA_BYTES > 0 && USE_TSTRB != 0) ? strb_q : '1;
   assign tx.tlast  = USE_TLAST != 0 ? last_q : 1'b1;
   assign tx.tdest  = TDEST_WIDTH > 0 ? dest_q : '0;
   assign tx.tuser  = TUSER_WIDTH > 0 ? user_q : '0;
   assign tx.tid    = TID_WIDTH > 0 ? id_q : '0;
endmodule
